// File: rtl/sa_pkg.sv
// Shared types for the systolic-array op sequencer: FSM states, the
// {load,write} mode decode, and the mode-to-state mapping.
package sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_MATMUL = 3'd4,
    ST_DONE   = 3'd5
  } sa_state_e;

  // Encoded directly as {load, write}.
  typedef enum logic [1:0] {
    MODE_MATMUL = 2'b00,
    MODE_WRITE  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_READ   = 2'b11
  } sa_mode_e;

  function automatic sa_state_e mode_to_state(input sa_mode_e m);
    sa_state_e s;
    case (m)
      MODE_LOAD:   s = ST_LOAD;
      MODE_WRITE:  s = ST_WRITE;
      MODE_READ:   s = ST_READ;
      MODE_MATMUL: s = ST_MATMUL;
      default:     s = ST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sa_step_counter.sv
// Saturating phase step counter. Counts 0..limit-1 while enabled and
// holds at limit-1; terminal flags the final step of the phase.
module sa_step_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Terminal step of the current phase.
  always_comb begin
    terminal = (count_q == (limit - CNT_W'(1)));
  end

  // Next count: clear wins, increment stops at the terminal step.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !terminal) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sa_op_sequencer.sv
// Operation sequencer for an N x N systolic array. Decodes {load,write}
// into LOAD / WRITE / MATMUL / READ, times LOAD and MATMUL phases, parks
// in DONE after a phase, and raises a completion pulse plus sticky flag.
// Every output is a flop; output flops are loaded from the next-state
// values so they line up with the state register.
module sa_op_sequencer
  import sa_pkg::*;
#(
  parameter int N           = 3,
  parameter int LOAD_CYCLES = N * N,
  parameter int MM_CYCLES   = 24,
  parameter int CNT_W       = $clog2(((LOAD_CYCLES > MM_CYCLES) ? LOAD_CYCLES : MM_CYCLES) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             write,
  input  logic             irq_en,
  input  logic             irq_clr,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] step_cnt,
  output logic             sa_load_en,
  output logic             sa_mm_en,
  output logic             sa_wr_en,
  output logic             sa_rd_en,
  output logic             busy,
  output logic             done_load,
  output logic             done_mm,
  output logic             int_to_ps,
  output logic             irq_status
);

  localparam logic [CNT_W-1:0] LOAD_LIMIT = CNT_W'(LOAD_CYCLES);
  localparam logic [CNT_W-1:0] MM_LIMIT   = CNT_W'(MM_CYCLES);

  sa_state_e state_q, state_d;
  sa_mode_e  op_q, op_d;
  sa_mode_e  mode;

  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_term;
  logic [CNT_W-1:0] cnt_limit;

  logic sa_load_en_q, sa_load_en_d;
  logic sa_mm_en_q,   sa_mm_en_d;
  logic sa_wr_en_q,   sa_wr_en_d;
  logic sa_rd_en_q,   sa_rd_en_d;
  logic busy_q,       busy_d;
  logic done_load_q,  done_load_d;
  logic done_mm_q,    done_mm_d;
  logic int_to_ps_q,  int_to_ps_d;
  logic irq_status_q, irq_status_d;

  sa_step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clr),
    .enable   (cnt_inc),
    .limit    (cnt_limit),
    .count    (step_cnt),
    .terminal (cnt_term)
  );

  // State, current/last op and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= MODE_MATMUL;
      sa_load_en_q <= 1'b0;
      sa_mm_en_q   <= 1'b0;
      sa_wr_en_q   <= 1'b0;
      sa_rd_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_load_q  <= 1'b0;
      done_mm_q    <= 1'b0;
      int_to_ps_q  <= 1'b0;
      irq_status_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sa_load_en_q <= sa_load_en_d;
      sa_mm_en_q   <= sa_mm_en_d;
      sa_wr_en_q   <= sa_wr_en_d;
      sa_rd_en_q   <= sa_rd_en_d;
      busy_q       <= busy_d;
      done_load_q  <= done_load_d;
      done_mm_q    <= done_mm_d;
      int_to_ps_q  <= int_to_ps_d;
      irq_status_q <= irq_status_d;
    end
  end

  // Next state: enable gate, mode change restart, phase timing.
  always_comb begin
    mode      = sa_mode_e'({load, write});
    state_d   = state_q;
    op_d      = op_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_limit = (state_q == ST_MATMUL) ? MM_LIMIT : LOAD_LIMIT;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else if ((state_q == ST_IDLE) || (mode != op_q)) begin
      state_d = mode_to_state(mode);
      op_d    = mode;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD, ST_MATMUL: begin
          if (cnt_term) begin
            state_d = ST_DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the next state; the completion pulse is the
  // entry into DONE, and a completion set beats a same-cycle clear.
  always_comb begin
    sa_load_en_d = (state_d == ST_LOAD);
    sa_mm_en_d   = (state_d == ST_MATMUL);
    sa_wr_en_d   = (state_d == ST_WRITE);
    sa_rd_en_d   = (state_d == ST_READ);
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_MATMUL);
    done_load_d  = (state_d == ST_DONE) && (op_d == MODE_LOAD);
    done_mm_d    = (state_d == ST_DONE) && (op_d == MODE_MATMUL);
    int_to_ps_d  = irq_en && (state_d == ST_DONE) && (state_q != ST_DONE);
    irq_status_d = irq_status_q;
    if (int_to_ps_d) begin
      irq_status_d = 1'b1;
    end else if (irq_clr) begin
      irq_status_d = 1'b0;
    end
  end

  assign state      = state_q;
  assign sa_load_en = sa_load_en_q;
  assign sa_mm_en   = sa_mm_en_q;
  assign sa_wr_en   = sa_wr_en_q;
  assign sa_rd_en   = sa_rd_en_q;
  assign busy       = busy_q;
  assign done_load  = done_load_q;
  assign done_mm    = done_mm_q;
  assign int_to_ps  = int_to_ps_q;
  assign irq_status = irq_status_q;

endmodule

// File: tb/tb_sa_op_sequencer.sv
// Directed bench for sa_op_sequencer: default-size instance plus an
// N=4 / 16 / 40 instance sharing the same stimulus.
module tb_sa_op_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_MM    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic clk = 1'b0;
  logic rst, en, load, write, irq_en, irq_clr;

  logic [2:0] state1;
  logic [4:0] cnt1;
  logic ld1, mm1, wr1, rd1, busy1, dl1, dm1, int1, irqs1;

  logic [2:0] state2;
  logic [5:0] cnt2;
  logic ld2, mm2, wr2, rd2, busy2, dl2, dm2, int2, irqs2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sa_op_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .write(write),
    .irq_en(irq_en), .irq_clr(irq_clr),
    .state(state1), .step_cnt(cnt1),
    .sa_load_en(ld1), .sa_mm_en(mm1), .sa_wr_en(wr1), .sa_rd_en(rd1),
    .busy(busy1), .done_load(dl1), .done_mm(dm1),
    .int_to_ps(int1), .irq_status(irqs1)
  );

  sa_op_sequencer #(.N(4), .LOAD_CYCLES(16), .MM_CYCLES(40)) dut_big (
    .clk(clk), .rst(rst), .en(en), .load(load), .write(write),
    .irq_en(irq_en), .irq_clr(irq_clr),
    .state(state2), .step_cnt(cnt2),
    .sa_load_en(ld2), .sa_mm_en(mm2), .sa_wr_en(wr2), .sa_rd_en(rd2),
    .busy(busy2), .done_load(dl2), .done_mm(dm2),
    .int_to_ps(int2), .irq_status(irqs2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; write = 1'b0;
    irq_en = 1'b0; irq_clr = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_state", 32'(state1), 32'(S_IDLE));
    chk("rst_cnt", 32'(cnt1), 0);
    chk("rst_strobes", {28'd0, ld1, mm1, wr1, rd1}, 0);
    chk("rst_flags", {27'd0, busy1, dl1, dm1, int1, irqs1}, 0);

    // LOAD phase: 9 cycles, then DONE with a pulse
    rst = 1'b1; en = 1'b1; load = 1'b1; write = 1'b0; irq_en = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      chk("load_en", 32'(ld1), 1);
      chk("load_cnt", 32'(cnt1), i);
      chk("load_busy", 32'(busy1), 1);
      chk("load_noint", 32'(int1), 0);
      tick();
    end
    chk("load_done_state", 32'(state1), 32'(S_DONE));
    chk("load_done_strobe", 32'(ld1), 0);
    chk("load_done_flag", 32'(dl1), 1);
    chk("load_done_mm_flag", 32'(dm1), 0);
    chk("load_int", 32'(int1), 1);
    chk("load_irqs", 32'(irqs1), 1);
    chk("load_done_cnt", 32'(cnt1), 8);
    tick();
    chk("load_int_once", 32'(int1), 0);
    chk("load_hold_state", 32'(state1), 32'(S_DONE));
    chk("load_hold_cnt", 32'(cnt1), 8);
    chk("load_hold_busy", 32'(busy1), 0);

    // MATMUL phase: 24 cycles, clear the old flag on entry
    load = 1'b0; write = 1'b0; irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("mm_entry_irqs", 32'(irqs1), 0);
    chk("mm_entry_dl", 32'(dl1), 0);
    for (int i = 0; i < 24; i++) begin
      chk("mm_en", 32'(mm1), 1);
      chk("mm_cnt", 32'(cnt1), i);
      chk("mm_noint", 32'(int1), 0);
      tick();
    end
    chk("mm_done_state", 32'(state1), 32'(S_DONE));
    chk("mm_done_flag", 32'(dm1), 1);
    chk("mm_int", 32'(int1), 1);
    chk("mm_irqs", 32'(irqs1), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mm_hold_state", 32'(state1), 32'(S_DONE));
      chk("mm_hold_cnt", 32'(cnt1), 23);
      chk("mm_hold_int", 32'(int1), 0);
      chk("mm_hold_irqs", 32'(irqs1), 1);
      chk("mm_hold_strobe", 32'(mm1), 0);
    end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_clr", 32'(irqs1), 0);
    tick();
    chk("irq_clr_hold", 32'(irqs1), 0);
    chk("irq_clr_state", 32'(state1), 32'(S_DONE));

    // LOAD abandoned at step 4 by switching to WRITE, then READ
    load = 1'b1; write = 1'b0;
    tick();
    tick(); tick(); tick(); tick();
    chk("abandon_cnt4", 32'(cnt1), 4);
    chk("abandon_state", 32'(state1), 32'(S_LOAD));
    load = 1'b0; write = 1'b1;
    tick();
    chk("wr_state", 32'(state1), 32'(S_WRITE));
    chk("wr_strobes", {28'd0, ld1, mm1, wr1, rd1}, 32'b0010);
    chk("wr_cnt", 32'(cnt1), 0);
    chk("wr_int", 32'(int1), 0);
    chk("wr_irqs", 32'(irqs1), 0);
    tick(); tick();
    chk("wr_stay", 32'(wr1), 1);
    chk("wr_stay_cnt", 32'(cnt1), 0);
    load = 1'b1; write = 1'b1;
    tick();
    chk("rd_state", 32'(state1), 32'(S_READ));
    chk("rd_strobes", {28'd0, ld1, mm1, wr1, rd1}, 32'b0001);

    // en=0 forces IDLE
    en = 1'b0;
    tick();
    chk("en0_state", 32'(state1), 32'(S_IDLE));
    chk("en0_strobes", {28'd0, ld1, mm1, wr1, rd1}, 0);

    // MATMUL with interrupts disabled
    irq_en = 1'b0; en = 1'b1; load = 1'b0; write = 1'b0;
    tick();
    for (int i = 0; i < 24; i++) begin
      chk("noirq_int", 32'(int1), 0);
      tick();
    end
    chk("noirq_state", 32'(state1), 32'(S_DONE));
    chk("noirq_int_done", 32'(int1), 0);
    chk("noirq_irqs", 32'(irqs1), 0);
    chk("noirq_dm", 32'(dm1), 1);

    // Rerun via en toggle; clear coincides with completion, set wins
    en = 1'b0;
    tick();
    irq_en = 1'b1; en = 1'b1;
    tick();
    chk("rerun_cnt0", 32'(cnt1), 0);
    for (int i = 0; i < 23; i++) tick();
    chk("rerun_cnt23", 32'(cnt1), 23);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("setwins_int", 32'(int1), 1);
    chk("setwins_irqs", 32'(irqs1), 1);
    tick();
    chk("setwins_hold", 32'(irqs1), 1);

    // Reset in MATMUL step 10
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("mid_cnt10", 32'(cnt1), 10);
    chk("mid_irqs", 32'(irqs1), 1);
    rst = 1'b0;
    tick();
    chk("midrst_state", 32'(state1), 32'(S_IDLE));
    chk("midrst_cnt", 32'(cnt1), 0);
    chk("midrst_strobes", {28'd0, ld1, mm1, wr1, rd1}, 0);
    chk("midrst_flags", {27'd0, busy1, dl1, dm1, int1, irqs1}, 0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) begin
      chk("fresh_mm_en", 32'(mm1), 1);
      chk("fresh_cnt", 32'(cnt1), i);
      tick();
    end
    chk("fresh_done", 32'(state1), 32'(S_DONE));
    chk("fresh_int", 32'(int1), 1);

    // Large instance: 16-cycle load, 40-cycle matmul
    rst = 1'b0;
    tick();
    rst = 1'b1; load = 1'b1; write = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("big_load_en", 32'(ld2), 1);
      chk("big_load_cnt", 32'(cnt2), i);
      tick();
    end
    chk("big_load_done", 32'(state2), 32'(S_DONE));
    chk("big_load_dl", 32'(dl2), 1);
    chk("big_load_cnt15", 32'(cnt2), 15);
    load = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) begin
      chk("big_mm_en", 32'(mm2), 1);
      chk("big_mm_cnt", 32'(cnt2), i);
      tick();
    end
    chk("big_mm_done", 32'(state2), 32'(S_DONE));
    chk("big_mm_dm", 32'(dm2), 1);
    chk("big_mm_cnt39", 32'(cnt2), 39);
    chk("big_mm_int", 32'(int2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_op_sequencer.md
SA_OP_SEQUENCER -- requirements
Module: sa_op_sequencer

Interface
REQ-001 SHALL provide parameter N, default 3, systolic array dimension (N x N PEs).
REQ-002 SHALL provide parameter LOAD_CYCLES, default N*N, cycles in one weight-load phase.
REQ-003 SHALL provide parameter MM_CYCLES, default 24, cycles in one matmul phase.
REQ-004 SHALL provide parameter CNT_W, default $clog2(max(LOAD_CYCLES,MM_CYCLES)+1), step counter width.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 en  input  1  sequencer enable; 0 forces IDLE.
REQ-008 load  input  1  mode bit; with write: 10=LOAD, 01=WRITE, 00=MATMUL, 11=READ.
REQ-009 write  input  1  mode bit, see REQ-008.
REQ-010 irq_en  input  1  enables interrupt generation.
REQ-011 irq_clr  input  1  clears sticky irq_status.
REQ-012 state  output  3  current FSM state encoding.
REQ-013 step_cnt  output  CNT_W  cycles elapsed in current LOAD/MATMUL phase.
REQ-014 sa_load_en, sa_mm_en, sa_wr_en, sa_rd_en  output  1 each  array-controller strobes.
REQ-015 busy  output  1  high in LOAD or MATMUL.
REQ-016 done_load, done_mm  output  1 each  level: last completed phase, held in DONE.
REQ-017 int_to_ps  output  1  one-cycle completion pulse to PS.
REQ-018 irq_status  output  1  sticky completion flag.

Function
REQ-019 SHALL implement states IDLE, WRITE, READ, LOAD, MATMUL, DONE; all outputs registered.
REQ-020 en=0 SHALL move to IDLE next cycle, clear step_cnt, drop all strobes, no pulse.
REQ-021 With en=1, decoded mode differing from current/last-completed op SHALL move next cycle to that mode's state, step_cnt=0; abandons any phase in progress, no pulse.
REQ-022 LOAD entered at cycle k: sa_load_en high k..k+LOAD_CYCLES-1, step_cnt=0..LOAD_CYCLES-1; DONE at k+LOAD_CYCLES with done_load=1.
REQ-023 MATMUL identical with sa_mm_en, MM_CYCLES, done_mm.
REQ-024 int_to_ps SHALL be high only the first DONE cycle and only if irq_en=1 then; irq_status set same cycle.
REQ-025 DONE SHALL hold (strobes low, step_cnt frozen) while mode unchanged; rerun only via mode change or en toggle.
REQ-026 WRITE/READ SHALL assert sa_wr_en/sa_rd_en every cycle in state; no counting, no interrupt.
REQ-027 irq_clr SHALL clear irq_status next cycle; simultaneous set and clr: set wins.
REQ-028 step_cnt SHALL never exceed its phase limit nor wrap.
REQ-029 done_load/done_mm SHALL be mutually exclusive and clear on leaving DONE.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE, step_cnt=0, all strobes, busy, done_*, int_to_ps, irq_status to 0, overriding all inputs, mid-phase included.
REQ-031 First state change SHALL occur on the first edge after rst returns high.

Structure
REQ-032 State enum and mode enum (LOAD/WRITE/MATMUL/READ) SHALL live in shared package sa_pkg.
REQ-033 Step counting SHALL be a sub-module sa_step_counter (clear, enable, limit, terminal flag, width CNT_W).
REQ-034 Size target 120-400 RTL lines; no combinational path input-to-output.

Verification
REQ-035 Reset, then en=1, load=1, write=0 -> sa_load_en high 9 cycles, DONE, done_load=1, one-cycle int_to_ps with irq_en=1.
REQ-036 en=1, load=0, write=0, irq_en=1 -> sa_mm_en high 24 cycles, step_cnt 0..23, single pulse, irq_status sticky until irq_clr.
REQ-037 LOAD at step_cnt=4, mode switched to WRITE -> next cycle WRITE, sa_wr_en=1, no int_to_ps, irq_status unchanged.
REQ-038 rst=0 during MATMUL step 10 -> next cycle all outputs 0, IDLE; after release with same mode, fresh 24-cycle phase.
REQ-039 MATMUL with irq_en=0 -> DONE reached, int_to_ps never high, irq_status 0; irq_clr asserted on DONE cycle with irq_en=1 -> irq_status=1.
REQ-040 Override N=4, LOAD_CYCLES=16, MM_CYCLES=40 -> load 16 cycles, matmul 40 cycles, CNT_W=6.
